// File: rtl/chip_link_pkg.sv
// Shared packing definitions for the inter-chip link (transmitter and receiver).
// Width helpers, default geometry, beat-index type and serializer state encoding.
package chip_link_pkg;

  // Ceiling log2 with a floor of 1, so a single-entry space still gets one select/index bit.
  function automatic int log2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int nbeat(input int dw, input int lw);
    return (dw + lw - 1) / lw;
  endfunction

  localparam int DEF_FW      = 59;
  localparam int DEF_CONNECT = 2;
  localparam int DEF_B       = 4;
  localparam int DEF_LW      = 16;
  localparam int DEF_SW      = log2(DEF_CONNECT);
  localparam int DEF_DW      = DEF_FW + DEF_SW;
  localparam int DEF_NBEAT   = nbeat(DEF_DW, DEF_LW);

  typedef logic [log2(DEF_NBEAT)-1:0] beat_idx_t;

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } tx_state_e;

endpackage

// File: rtl/chip_link_tx_if.sv
// Mux-side word stream, pin-level beat link and status of the link transmitter.
interface chip_link_tx_if #(
    parameter int DW = chip_link_pkg::DEF_DW,
    parameter int LW = chip_link_pkg::DEF_LW,
    parameter int B  = chip_link_pkg::DEF_B
) ();

    logic          data_in_wr;
    logic [DW-1:0] data_in;
    logic          send_fifo_full;
    logic          link_valid;
    logic          link_ready;
    logic [LW-1:0] link_data;
    logic          link_last;
    logic [B:0]    fifo_count;
    logic          overflow_err;

    modport master (
        output data_in_wr, data_in, link_ready,
        input  send_fifo_full, link_valid, link_data, link_last, fifo_count, overflow_err
    );

    modport slave (
        input  data_in_wr, data_in, link_ready,
        output send_fifo_full, link_valid, link_data, link_last, fifo_count, overflow_err
    );

endinterface

// File: rtl/chip_link_fifo.sv
// Send FIFO: DEPTH x DW storage with combinational head, occupancy count and sticky overflow.
module chip_link_fifo
    import chip_link_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int B  = DEF_B
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic [B:0]    count,
    output logic          empty,
    output logic          overflow
);

    localparam int DEPTH = 1 << B;

    logic [DW-1:0] mem [DEPTH];
    logic [B-1:0]  wr_ptr;
    logic [B-1:0]  rd_ptr;
    logic [B:0]    count_q;
    logic          ovf_q;
    logic          full;
    logic          push;
    logic          pop;

    assign full  = (count_q == (B+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = wr_en && !full;
    assign pop   = rd_en && !empty;

    // NOTE: storage is deliberately left out of reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            // A dropped write is remembered until the next reset.
            if (wr_en && full) ovf_q <= 1'b1;
        end
    end

    assign rd_data  = mem[rd_ptr];
    assign count    = count_q;
    assign overflow = ovf_q;

endmodule

// File: rtl/chip_link_tx.sv
// Off-chip link transmitter: buffers tagged words from the connection mux and
// serializes each one LSB-first into LW-bit valid/ready beats toward the peer chip.
module chip_link_tx
    import chip_link_pkg::*;
#(
    parameter int FW      = DEF_FW,
    parameter int CONNECT = DEF_CONNECT,
    parameter int B       = DEF_B,
    parameter int LW      = DEF_LW
) (
    input  logic           clk,
    input  logic           rst_n,
    chip_link_tx_if.slave  bus
);

    localparam int SW    = log2(CONNECT);
    localparam int DW    = FW + SW;
    localparam int NBEAT = nbeat(DW, LW);
    localparam int SRW   = NBEAT * LW;
    localparam int BW    = log2(NBEAT);
    localparam int DEPTH = 1 << B;

    logic [DW-1:0]  head;
    logic [B:0]     count;
    logic           empty;
    logic           overflow;
    logic           pop;
    logic           shift;
    logic           last;
    tx_state_e      state;
    tx_state_e      state_nxt;
    logic [SRW-1:0] sr;
    logic [BW-1:0]  beat;

    chip_link_fifo #(.DW(DW), .B(B)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (bus.data_in_wr),
        .wr_data  (bus.data_in),
        .rd_en    (pop),
        .rd_data  (head),
        .count    (count),
        .empty    (empty),
        .overflow (overflow)
    );

    assign last = (beat == BW'(NBEAT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // A last-beat accept with a non-empty FIFO reloads in place, so words go out with no bubble.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        shift     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (bus.link_ready) begin
                    if (!last)       shift     = 1'b1;
                    else if (!empty) pop       = 1'b1;
                    else             state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr   <= '0;
            beat <= '0;
        end else if (pop) begin
            sr   <= SRW'(head);
            beat <= '0;
        end else if (shift) begin
            sr   <= sr >> LW;
            beat <= beat + 1'b1;
        end
    end

    // Threshold leaves room for the mux's grant-to-strobe delay plus one word in flight.
    assign bus.send_fifo_full = (count >= (B+1)'(DEPTH - 2));
    assign bus.link_valid     = (state == ST_SEND);
    assign bus.link_data      = (state == ST_SEND) ? sr[LW-1:0] : '0;
    assign bus.link_last      = (state == ST_SEND) && last;
    assign bus.fifo_count     = count;
    assign bus.overflow_err   = overflow;

endmodule
